// File: rtl/serial_adder_feeder.sv
// Parallel-to-serial operand feeder and serial-to-parallel result collector
// wrapped around one bit-serial adder (LSB first, one bit per enabled cycle).
module serial_adder_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             ser_en,
    output logic             ser_vld,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_last,
    input  logic             ser_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   res_sh;

    // Sum bits arrive LSB first, so each one enters at the top and slides down.
    assign res_sh = {ser_sum, res_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        ser_vld   = 1'b0;
        ser_a     = 1'b0;
        ser_b     = 1'b0;
        ser_last  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_a_d  = in_a;
                    op_b_d  = in_b;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ser_vld  = ser_en;
                ser_a    = op_a_q[0];
                ser_b    = op_b_q[0];
                ser_last = ser_en && (cnt_q == LAST_IDX);
                if (ser_en) begin
                    op_a_d = op_a_q >> 1;
                    op_b_d = op_b_q >> 1;
                    res_d  = res_sh[WIDTH:1];
                    cnt_d  = cnt_q + CW'(1);
                    if (ser_last) state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = res_q;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_adder_feeder.sv
// Bench for serial_adder_feeder: WIDTH=8 and WIDTH=1 instances, each driving a
// behavioural bit-serial adder; results checked against plain modular addition.
module tb_serial_adder_feeder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       in_valid = 1'b0, in_ready, ser_en = 1'b0, out_ready = 1'b1;
    logic [7:0] in_a = '0, in_b = '0, out_sum;
    logic       ser_vld, ser_a, ser_b, ser_last, ser_sum, out_valid;
    logic       c8;

    // WIDTH=1 instance
    logic       in_valid1 = 1'b0, in_ready1, ser_en1 = 1'b0, out_ready1 = 1'b1;
    logic [0:0] in_a1 = '0, in_b1 = '0, out_sum1;
    logic       ser_vld1, ser_a1, ser_b1, ser_last1, ser_sum1, out_valid1;
    logic       c1;

    int checks = 0;
    int errors = 0;

    serial_adder_feeder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .ser_en(ser_en), .ser_vld(ser_vld),
        .ser_a(ser_a), .ser_b(ser_b), .ser_last(ser_last), .ser_sum(ser_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    serial_adder_feeder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .ser_en(ser_en1), .ser_vld(ser_vld1),
        .ser_a(ser_a1), .ser_b(ser_b1), .ser_last(ser_last1), .ser_sum(ser_sum1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1)
    );

    // Serial adder: combinational sum, carry kept across vld bits, cleared after last.
    assign ser_sum  = ser_a ^ ser_b ^ c8;
    assign ser_sum1 = ser_a1 ^ ser_b1 ^ c1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c8 <= 1'b0;
            c1 <= 1'b0;
        end else begin
            if (ser_vld)  c8 <= ser_last  ? 1'b0 : ((ser_a & ser_b) | (ser_a & c8) | (ser_b & c8));
            if (ser_vld1) c1 <= ser_last1 ? 1'b0 : ((ser_a1 & ser_b1) | (ser_a1 & c1) | (ser_b1 & c1));
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         mode;   // 0: ser_en high, 1: 1,0,0 pattern, 2: random
        int         hold;   // cycles out_ready stays low after out_valid
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_in_ready"}, int'(in_ready), 1);
        chk({nm, "_ser"}, int'({ser_vld, ser_a, ser_b, ser_last}), 0);
        chk({nm, "_out_valid"}, int'(out_valid), 0);
        chk({nm, "_out_sum"}, int'(out_sum), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input int mode,
                            input int hold, input logic [7:0] exp, input string nm);
        int cyc, nv, nlast, last_cyc, bad, hold_bad, w;
        logic [7:0] s0, sum;
        cyc = 0; nv = 0; nlast = 0; last_cyc = -1; bad = 0; hold_bad = 0;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        in_a     = $urandom();
        in_b     = $urandom();
        cyc = 1;
        while (cyc < 200) begin
            ser_en = (mode == 0) ? 1'b1 :
                     (mode == 1) ? ((cyc - 1) % 3 == 0) : ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid) break;
            if (ser_vld != ser_en) bad++;
            if (ser_vld) begin
                if (nv < 8 && (ser_a != a[nv] || ser_b != b[nv])) bad++;
                if (ser_last) begin
                    nlast++;
                    last_cyc = cyc;
                    if (nv != 7) bad++;
                end
                nv++;
            end else if (ser_last) bad++;
            tick();
            cyc++;
        end
        chk({nm, "_done_seen"}, int'(out_valid), 1);
        s0 = out_sum;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_a     = $urandom();
            in_b     = $urandom();
            #1;
            if (out_sum != s0 || in_ready || !out_valid || ser_vld) hold_bad++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        sum = out_sum;
        tick();
        chk({nm, "_sum"}, int'(sum), int'(exp));
        chk({nm, "_vld_count"}, nv, 8);
        chk({nm, "_last_count"}, nlast, 1);
        chk({nm, "_stream_bad"}, bad, 0);
        chk({nm, "_hold_bad"}, hold_bad, 0);
        chk({nm, "_in_ready_after"}, int'(in_ready), 1);
        if (mode == 0) begin
            chk({nm, "_last_cycle"}, last_cyc, 8);
            chk({nm, "_valid_cycle"}, cyc, 9);
        end
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{a: 8'd3,   b: 8'd5,   mode: 0, hold: 0, exp: 8'd8};
        tbl[1] = '{a: 8'd255, b: 8'd1,   mode: 0, hold: 0, exp: 8'd0};
        tbl[2] = '{a: 8'd200, b: 8'd100, mode: 0, hold: 0, exp: 8'd44};
        tbl[3] = '{a: 8'hA5,  b: 8'h3C,  mode: 1, hold: 0, exp: 8'hE1};
        tbl[4] = '{a: 8'h12,  b: 8'h34,  mode: 0, hold: 5, exp: 8'h46};

        #12;
        chk_reset_outputs("reset");
        chk("reset_w1_in_ready", int'(in_ready1), 1);
        chk("reset_w1_out_valid", int'(out_valid1), 0);
        #2 rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            do_frame(tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].hold, tbl[i].exp,
                     $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom());
            rb = 8'($urandom());
            do_frame(ra, rb, 2, $urandom_range(0, 2), 8'((int'(ra) + int'(rb)) % 256),
                     $sformatf("rnd%0d", i));
        end

        // Abort a frame with reset in cycle 4.
        ser_en    = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'hFF;
        in_b      = 8'hFF;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 4; c++) tick();
        chk("mid_vld_before_reset", int'(ser_vld), 1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        #3 rst = 1'b1;
        tick();
        do_frame(8'd7, 8'd9, 0, 0, 8'd16, "post_reset");

        // WIDTH=1: a single bit that is also the last one.
        ser_en1    = 1'b1;
        in_valid1  = 1'b1;
        in_a1      = 1'b1;
        in_b1      = 1'b1;
        tick();
        in_valid1 = 1'b0;
        chk("w1_vld", int'(ser_vld1), 1);
        chk("w1_last", int'(ser_last1), 1);
        chk("w1_bits", int'({ser_a1, ser_b1}), 3);
        chk("w1_sum_bit", int'(ser_sum1), 0);
        tick();
        chk("w1_out_valid", int'(out_valid1), 1);
        chk("w1_out_sum", int'(out_sum1), 0);
        chk("w1_ser_idle", int'({ser_vld1, ser_last1}), 0);
        tick();
        chk("w1_in_ready", int'(in_ready1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_feeder.md
# serial_adder_feeder

Parallel-to-serial front end and serial-to-parallel back end for the bit-serial adder. It accepts a pair of WIDTH-bit operands over a valid/ready handshake and streams them LSB-first as the adder's vld/a/b/last bit stream. It collects the returned sum bits and presents the WIDTH-bit result over a second valid/ready handshake. It sits between a parallel datapath and one serial adder instance; both blocks share clk and rst.

## Interface

Parameters:
- WIDTH, default 8: operand and result width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair on in_a/in_b is valid.
- in_ready  output  1  block can accept an operand pair (high only in IDLE).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- ser_en  input  1  pacing enable; when low, no bit is emitted this cycle.
- ser_vld  output  1  to adder vld.
- ser_a  output  1  to adder a.
- ser_b  output  1  to adder b.
- ser_last  output  1  to adder last.
- ser_sum  input  1  from adder sum; combinational in the same cycle as ser_a/ser_b.
- out_valid  output  1  out_sum holds a completed result.
- out_ready  input  1  consumer accepts out_sum.
- out_sum  output  WIDTH  (in_a + in_b) mod 2^WIDTH; the carry-out is discarded.

## Operation

- FSM states are IDLE, SHIFT and DONE. Registers:
  - op_a and op_b (WIDTH each), the operand shift registers.
  - res (WIDTH), the result shift register.
  - cnt ($clog2(WIDTH) bits, minimum 1), the bit index.
- IDLE: in_ready=1.
  - When in_valid && in_ready: load op_a<=in_a, op_b<=in_b, cnt<=0, and go to SHIFT.
- SHIFT:
  - ser_vld = ser_en (combinational).
  - ser_a = op_a[0], ser_b = op_b[0].
  - ser_last = ser_en && (cnt == WIDTH-1).
  - On a clock edge where ser_vld=1: shift op_a and op_b right by one, shift ser_sum into res from the MSB end (res <= {ser_sum, res[WIDTH-1:1]}), and increment cnt.
  - If ser_last is also 1 on that edge, go to DONE.
  - While ser_en=0: all SHIFT state holds and ser_vld=ser_last=0.
- DONE: out_valid=1 and out_sum=res, held stable until accepted.
  - When out_valid && out_ready: go to IDLE.
- Outside SHIFT, ser_vld, ser_a, ser_b and ser_last are driven 0.
- in_valid is ignored outside IDLE. Only one operation is in flight at a time; no buffering.
- WIDTH=1: the single emitted bit carries ser_last=1.
- Reset (rst=0, asynchronous) from any state:
  - Go to IDLE; clear op_a, op_b, res and cnt.
  - Outputs: in_ready=1; ser_vld, ser_a, ser_b, ser_last, out_valid and out_sum all 0.
- A reset in the middle of SHIFT aborts the frame with no ser_last emitted. The shared reset also clears the adder carry, so the next frame starts clean.

## Timing

- Accept edge = cycle 0. With ser_en held high:
  - Bit i is emitted in cycle i+1, for i = 0..WIDTH-1.
  - ser_last is high in cycle WIDTH.
  - out_valid rises in cycle WIDTH+1.
- Each ser_en=0 cycle during SHIFT adds one cycle of latency.
- Minimum period between accepts with out_ready=1 is WIDTH+2 cycles:
  - out handshake in cycle WIDTH+1;
  - IDLE and in_ready=1 in cycle WIDTH+2.
- in_ready and out_valid are decoded from state registers only; neither has a combinational path from in_valid or out_ready.
- ser_vld and ser_last depend combinationally on ser_en.
- ser_sum is sampled only on edges where ser_vld=1.

## Test plan

- WIDTH=8, in_a=8'd3, in_b=8'd5, ser_en=1, out_ready=1 → bits emitted in cycles 1..8, ser_last only in cycle 8, out_valid in cycle 9 with out_sum=8'd8, in_ready high again in cycle 10.
- WIDTH=8, 8'd255 + 8'd1 → out_sum=8'd0 (carry dropped). Then 8'd200 + 8'd100 → out_sum=8'd44, which proves no carry leaks across frames.
- ser_en pattern 1,0,0,1,... during SHIFT, 8'hA5 + 8'h3C → ser_vld=0 in gap cycles with no shifting, ser_vld count equals 8, out_sum=8'hE1.
- out_ready held 0 for 5 cycles after out_valid → out_sum stable, in_ready=0, in_valid pulses ignored; accepted on the first out_ready=1 edge.
- Reset asserted in cycle 4 of a frame → all outputs at reset values immediately. After release, 8'd7 + 8'd9 → out_sum=8'd16.
- WIDTH=1, in_a=1, in_b=1 → one bit with ser_vld=ser_last=1, out_sum=1'b0, out_valid in cycle 2.
